// File: rtl/touch_scan_pkg.sv
// touch_scan_pkg: shared types for the touch scanner.
//   i2c_cmd_t  - command encoding understood by the byte-level I2C master
//   state_t    - scanner FSM states
//   N_SENSORS  - jacks per scan, N_BYTES - bytes read per burst (2 per jack)
package touch_scan_pkg;

   localparam int unsigned N_SENSORS = 8;
   localparam int unsigned N_BYTES   = 16;

   typedef enum logic [2:0] {
      I2C_START     = 3'd0,
      I2C_WRITE     = 3'd1,
      I2C_READ_ACK  = 3'd2,
      I2C_READ_NACK = 3'd3,
      I2C_STOP      = 3'd4
   } i2c_cmd_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_W_ADDR,
      ST_W_REG,
      ST_RESTART,
      ST_W_ADDRR,
      ST_RD,
      ST_STOP,
      ST_COMMIT,
      ST_ERR_STOP
   } state_t;

endpackage

// File: rtl/touch_scan_sat.sv
// touch_sat: combinational scale and saturate of one 16-bit difference count.
//   count  in  16  raw unsigned difference count
//   sat    out 8   (count >> SHIFT) clamped to 255
module touch_sat #(
   parameter int unsigned SHIFT = 2
) (
   input  logic [15:0] count,
   output logic [7:0]  sat
);

   logic [15:0] scaled;

   always_comb begin
      scaled = count >> SHIFT;
      sat    = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
   end

endmodule

// File: rtl/touch_scan.sv
// touch_scan: polls the capacitive touch controller through a byte-level I2C
// master and publishes one scaled/saturated byte per jack.
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake towards the I2C master
//   cmd, cmd_data            i2c_cmd_t command and WRITE byte (0 otherwise)
//   rsp_valid/data/nack      completion pulse of WRITE / READ_* commands
//   touch0..touch7           committed touch values
//   touch_valid              one-cycle pulse when touch0..7 change
//   scan_err                 latest scan aborted on NACK; cleared by a good commit
import touch_scan_pkg::*;

module touch_scan #(
   parameter int unsigned SCAN_PERIOD = 50000,
   parameter logic [6:0]  DEV_ADDR    = 7'h37,
   parameter logic [7:0]  REG_BASE    = 8'hBA,
   parameter int unsigned SHIFT       = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [2:0] cmd,
   output logic [7:0] cmd_data,
   input  logic       rsp_valid,
   input  logic [7:0] rsp_data,
   input  logic       rsp_nack,
   output logic [7:0] touch0,
   output logic [7:0] touch1,
   output logic [7:0] touch2,
   output logic [7:0] touch3,
   output logic [7:0] touch4,
   output logic [7:0] touch5,
   output logic [7:0] touch6,
   output logic [7:0] touch7,
   output logic       touch_valid,
   output logic       scan_err
);

   localparam int unsigned     CNT_W  = $clog2(SCAN_PERIOD);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SCAN_PERIOD - 1);

   state_t           state;
   logic             wait_rsp;   // command transferred, awaiting rsp_valid
   logic [3:0]       byte_idx;
   logic [CNT_W-1:0] period_cnt;
   logic             scan_due;
   logic [15:0]      shadow  [N_SENSORS];
   logic [7:0]       touch_q [N_SENSORS];
   logic [7:0]       sat_val [N_SENSORS];

   i2c_cmd_t         cmd_c;
   logic [7:0]       data_c;
   logic             has_cmd;
   logic             xfer;

   // A due tick outside IDLE is simply dropped: no queueing of overrun scans.
   assign scan_due = (period_cnt == '0);

   // Command is a pure function of state, so it stays stable while stalled.
   always_comb begin
      cmd_c   = I2C_START;
      data_c  = '0;
      has_cmd = 1'b0;
      case (state)
         ST_START, ST_RESTART: begin
            has_cmd = 1'b1;
         end
         ST_W_ADDR: begin
            has_cmd = 1'b1;
            cmd_c   = I2C_WRITE;
            data_c  = {DEV_ADDR, 1'b0};
         end
         ST_W_REG: begin
            has_cmd = 1'b1;
            cmd_c   = I2C_WRITE;
            data_c  = REG_BASE;
         end
         ST_W_ADDRR: begin
            has_cmd = 1'b1;
            cmd_c   = I2C_WRITE;
            data_c  = {DEV_ADDR, 1'b1};
         end
         ST_RD: begin
            has_cmd = 1'b1;
            cmd_c   = (byte_idx == 4'd15) ? I2C_READ_NACK : I2C_READ_ACK;
         end
         ST_STOP, ST_ERR_STOP: begin
            has_cmd = 1'b1;
            cmd_c   = I2C_STOP;
         end
         default: has_cmd = 1'b0;
      endcase
   end

   assign cmd_valid = has_cmd && !wait_rsp;
   assign cmd       = cmd_c;
   assign cmd_data  = data_c;
   assign xfer      = cmd_valid && cmd_ready;

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_sat
      touch_sat #(.SHIFT(SHIFT)) u_sat (
         .count (shadow[g]),
         .sat   (sat_val[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         wait_rsp    <= 1'b0;
         byte_idx    <= '0;
         period_cnt  <= RELOAD;
         touch_valid <= 1'b0;
         scan_err    <= 1'b0;
         for (int unsigned i = 0; i < N_SENSORS; i++) begin
            shadow[i]  <= '0;
            touch_q[i] <= '0;
         end
      end else begin
         touch_valid <= 1'b0;
         period_cnt  <= scan_due ? RELOAD : period_cnt - CNT_W'(1);

         case (state)
            ST_IDLE: begin
               if (scan_due) state <= ST_START;
            end
            ST_START: begin
               if (xfer) state <= ST_W_ADDR;
            end
            ST_W_ADDR, ST_W_REG, ST_W_ADDRR: begin
               if (xfer) begin
                  wait_rsp <= 1'b1;
               end else if (wait_rsp && rsp_valid) begin
                  wait_rsp <= 1'b0;
                  if (rsp_nack) begin
                     state    <= ST_ERR_STOP;
                     scan_err <= 1'b1;
                  end else if (state == ST_W_ADDR) begin
                     state <= ST_W_REG;
                  end else if (state == ST_W_REG) begin
                     state <= ST_RESTART;
                  end else begin
                     state    <= ST_RD;
                     byte_idx <= '0;
                  end
               end
            end
            ST_RESTART: begin
               if (xfer) state <= ST_W_ADDRR;
            end
            ST_RD: begin
               if (xfer) begin
                  wait_rsp <= 1'b1;
               end else if (wait_rsp && rsp_valid) begin
                  wait_rsp <= 1'b0;
                  // Little-endian pairs: even byte is LSB, odd byte is MSB.
                  if (byte_idx[0]) shadow[byte_idx[3:1]][15:8] <= rsp_data;
                  else             shadow[byte_idx[3:1]][7:0]  <= rsp_data;
                  if (byte_idx == 4'd15) state <= ST_STOP;
                  else                   byte_idx <= byte_idx + 4'd1;
               end
            end
            ST_STOP: begin
               // Outputs and pulse are registered on the STOP transfer edge so
               // they are visible for exactly the COMMIT cycle.
               if (xfer) begin
                  state       <= ST_COMMIT;
                  touch_valid <= 1'b1;
                  scan_err    <= 1'b0;
                  for (int unsigned i = 0; i < N_SENSORS; i++) begin
                     touch_q[i] <= sat_val[i];
                  end
               end
            end
            ST_COMMIT: begin
               state <= ST_IDLE;
            end
            ST_ERR_STOP: begin
               if (xfer) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign touch0 = touch_q[0];
   assign touch1 = touch_q[1];
   assign touch2 = touch_q[2];
   assign touch3 = touch_q[3];
   assign touch4 = touch_q[4];
   assign touch5 = touch_q[5];
   assign touch6 = touch_q[6];
   assign touch7 = touch_q[7];

endmodule

// File: tb/tb_touch_scan.sv
`timescale 1ns/1ps
module tb_touch_scan;
   import touch_scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid;
   logic       cmd_ready = 1'b0;
   logic [2:0] cmd;
   logic [7:0] cmd_data;
   logic       rsp_valid = 1'b0;
   logic [7:0] rsp_data  = 8'h00;
   logic       rsp_nack  = 1'b0;
   logic [7:0] touch0, touch1, touch2, touch3, touch4, touch5, touch6, touch7;
   logic       touch_valid, scan_err;
   logic [63:0] touch_vec;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   touch_scan #(
      .SCAN_PERIOD (64),
      .DEV_ADDR    (7'h37),
      .REG_BASE    (8'hBA),
      .SHIFT       (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd         (cmd),
      .cmd_data    (cmd_data),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_nack    (rsp_nack),
      .touch0      (touch0),
      .touch1      (touch1),
      .touch2      (touch2),
      .touch3      (touch3),
      .touch4      (touch4),
      .touch5      (touch5),
      .touch6      (touch6),
      .touch7      (touch7),
      .touch_valid (touch_valid),
      .scan_err    (scan_err)
   );

   assign touch_vec = {touch7, touch6, touch5, touch4, touch3, touch2, touch1, touch0};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   int          stall = 0;       // cycles cmd_ready is held low per command
   int          lat   = 1;       // response latency in cycles (>=1)
   bit          rand_mode = 1'b0;
   bit          nack_once = 1'b0;
   logic [15:0] counts [8];
   logic [7:0]  served [16];
   int          pos, rd_k, pend, stall_left;
   bit          armed, after_nack, scan_nack, ev_stop, ev_nack, pend_nack;
   logic [7:0]  pend_data;
   logic [2:0]  hold_cmd;
   logic [7:0]  hold_data;
   logic [63:0] exp_touch = '0;
   bit          exp_err = 1'b0;
   int          ncommit = 0;
   int          nstart  = 0;

   function automatic logic [7:0] ref_touch(input logic [15:0] c);
      int unsigned v;
      v = c;
      v = v / 4;
      return (v > 255) ? 8'd255 : v[7:0];
   endfunction

   // Expected transaction of one scan, position 0..21.
   function automatic logic [10:0] seq_at(input int p);
      if (p == 0 || p == 3) return {I2C_START, 8'h00};
      if (p == 1)           return {I2C_WRITE, 8'h6E};
      if (p == 2)           return {I2C_WRITE, 8'hBA};
      if (p == 4)           return {I2C_WRITE, 8'h6F};
      if (p <= 19)          return {I2C_READ_ACK, 8'h00};
      if (p == 20)          return {I2C_READ_NACK, 8'h00};
      return {I2C_STOP, 8'h00};
   endfunction

   task automatic model_xfer();
      int         p;
      bit         an;
      logic [10:0] e;
      p  = pos;
      an = after_nack;
      e  = an ? {I2C_STOP, 8'h00} : seq_at(p);
      chk("cmd_seq", {cmd, cmd_data}, e);
      if (an) begin
         if (cmd == I2C_STOP) begin
            after_nack = 1'b0;
            pos        = 0;
         end
      end else begin
         pos = (p == 21) ? 0 : p + 1;
      end
      if (cmd == I2C_START) begin
         if (p == 0 && !an) begin
            scan_nack = 1'b0;
            nstart++;
            if (rand_mode) begin
               for (int i = 0; i < 8; i++) begin
                  if ($urandom_range(0, 3) == 0) counts[i] = 16'($urandom);
                  else                           counts[i] = 16'($urandom_range(0, 1100));
               end
            end
         end
         rd_k = 0;
      end else if (cmd == I2C_WRITE) begin
         pend      = lat;
         pend_data = 8'h00;
         pend_nack = nack_once && (cmd_data == 8'h6E);
         if (pend_nack) begin
            nack_once  = 1'b0;
            after_nack = 1'b1;
            scan_nack  = 1'b1;
         end
      end else if (cmd == I2C_READ_ACK || cmd == I2C_READ_NACK) begin
         pend      = lat;
         pend_nack = 1'b0;
         pend_data = (rd_k % 2 == 0) ? counts[rd_k / 2][7:0] : counts[rd_k / 2][15:8];
         if (rd_k < 16) begin
            served[rd_k] = pend_data;
            rd_k++;
         end
      end else if (cmd == I2C_STOP) begin
         if (!scan_nack && !an) ev_stop = 1'b1;
      end
   endtask

   // I2C slave model plus per-cycle output checks, all at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            cmd_ready  = 1'b0;
            rsp_valid  = 1'b0;
            rsp_nack   = 1'b0;
            rsp_data   = 8'h00;
            pend       = 0;
            pos        = 0;
            rd_k       = 0;
            armed      = 1'b0;
            after_nack = 1'b0;
            scan_nack  = 1'b0;
            ev_stop    = 1'b0;
            ev_nack    = 1'b0;
            exp_err    = 1'b0;
            exp_touch  = '0;
         end else begin
            if (ev_stop) begin
               exp_err = 1'b0;
               for (int i = 0; i < 8; i++)
                  exp_touch[8*i +: 8] = ref_touch({served[2*i+1], served[2*i]});
            end
            if (ev_nack) exp_err = 1'b1;
            chk("touch_valid", touch_valid, ev_stop);
            if (touch_valid) ncommit++;
            chk("scan_err", scan_err, exp_err);
            chk("touch", touch_vec, exp_touch);
            ev_stop   = 1'b0;
            ev_nack   = 1'b0;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            rsp_data  = 8'h00;
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  rsp_valid = 1'b1;
                  rsp_nack  = pend_nack;
                  rsp_data  = pend_data;
                  ev_nack   = pend_nack;
               end
            end
            cmd_ready = 1'b0;
            if (cmd_valid) begin
               if (!armed) begin
                  armed      = 1'b1;
                  stall_left = stall;
                  hold_cmd   = cmd;
                  hold_data  = cmd_data;
               end else begin
                  chk("cmd_hold", {cmd, cmd_data}, {hold_cmd, hold_data});
               end
               if (stall_left > 0) begin
                  stall_left--;
               end else begin
                  cmd_ready = 1'b1;
                  armed     = 1'b0;
                  model_xfer();
               end
            end
         end
      end
   end

   task automatic wait_commits(input int n, input int budget, input string tag);
      int target;
      int c;
      target = ncommit + n;
      c      = 0;
      while (ncommit < target && c < budget) begin
         @(negedge clk); #1;
         c++;
      end
      chk(tag, (ncommit >= target), 1);
   endtask

   task automatic release_and_time_start(input string tag);
      int n;
      @(negedge clk); #1;
      rst = 1'b0;
      n   = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!cmd_valid && n < 300);
      chk(tag, n, 64);
   endtask

   localparam logic [63:0] TEST1_TOUCH = 64'h0240_FFFF_FFFF_0100;

   initial begin
      int c;
      int s0;
      counts = '{16'h0000, 16'h0004, 16'h03FC, 16'h03FF, 16'h0400, 16'hFFFF, 16'h0100, 16'h0008};

      // Reset state and first-scan latency
      repeat (3) @(negedge clk);
      #1;
      chk("rst_touch", touch_vec, 64'h0);
      chk("rst_ctrl", {cmd_valid, cmd, cmd_data, touch_valid, scan_err}, 64'h0);
      release_and_time_start("first_start");

      // Directed boundary counts, always-ready model
      wait_commits(1, 400, "commit1_timeout");
      chk("test1_touch", touch_vec, TEST1_TOUCH);
      chk("test1_ncommit", ncommit, 1);

      // Device-address NACK, then recovery
      nack_once = 1'b1;
      rand_mode = 1'b1;
      c = 0;
      while (!scan_err && c < 1000) begin
         @(negedge clk); #1;
         c++;
      end
      chk("nack_err", scan_err, 1);
      chk("nack_touch_kept", touch_vec, TEST1_TOUCH);
      chk("nack_no_commit", ncommit, 1);
      wait_commits(1, 1000, "recover_timeout");
      chk("recover_err_clear", scan_err, 0);

      // Stalled handshake, same data as the first scan
      rand_mode = 1'b0;
      counts = '{16'h0000, 16'h0004, 16'h03FC, 16'h03FF, 16'h0400, 16'hFFFF, 16'h0100, 16'h0008};
      stall = 10;
      wait_commits(1, 3000, "stall_timeout");
      chk("stall_touch", touch_vec, TEST1_TOUCH);

      // Slow slave: scans longer than the period, overruns dropped
      stall     = 3;
      lat       = 4;
      rand_mode = 1'b1;
      s0        = nstart;
      wait_commits(3, 4000, "slow_timeout");
      chk("slow_start_vs_commit", nstart - s0, 3);

      // Reset in the middle of the read burst (byte 7 about to transfer)
      stall = 0;
      lat   = 1;
      c     = 0;
      while (c < 1000) begin
         @(negedge clk); #1;
         c++;
         if (rd_k == 8 && pend > 0) break;
      end
      chk("rd7_reached", (rd_k == 8), 1);
      rst = 1'b1;
      #1;
      chk("midrst_touch", touch_vec, 64'h0);
      chk("midrst_ctrl", {cmd_valid, cmd, cmd_data, touch_valid, scan_err}, 64'h0);
      s0 = ncommit;
      repeat (2) @(negedge clk);
      release_and_time_start("post_rst_start");
      chk("post_rst_no_early_commit", ncommit, s0);
      wait_commits(1, 400, "post_rst_commit");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
